soc_wb_ext_responder: RTL and testbench
=======================================

// Module: soc_wb_ext_responder
// PURPOSE
//   Wishbone B3 slave terminating the SoC external bus (wb_ext_*) driven by the mpsoc4d_or1k top.
//   It is the responder for the system's outbound initiator.
//   Holds a word-addressed local memory and answers classic and incrementing-burst cycles
//   with ack/err after configurable wait states.
//   Used in benches and FPGA builds in place of a real external peripheral.
// PARAMETERS
//   DW          32       data width; multiple of 8; SW = DW/8 byte selects
//   AW          32       address width (byte address)
//   MEM_WORDS   1024     memory depth in DW-bit words; power of two
//   BASE_ADDR   32'h0    byte base of decoded window; aligned to MEM_WORDS*SW
//   WAIT_STATES 0        extra cycles before first ack of each cycle/burst (0..15)
// PORTS
//   clk       in   1    single clock; all logic on rising edge
//   rst       in   1    synchronous reset, active-high
//   wb_adr_i  in   AW   byte address; low log2(SW) bits ignored
//   wb_dat_i  in   DW   write data
//   wb_sel_i  in   SW   byte enables (writes only)
//   wb_we_i   in   1    1 = write
//   wb_cyc_i  in   1    bus cycle valid
//   wb_stb_i  in   1    strobe
//   wb_cti_i  in   3    cycle type: 000 classic, 010 incr burst, 111 end-of-burst; others treated as classic
//   wb_bte_i  in   2    burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16
//   wb_cab_i  in   1    legacy; ignored
//   wb_dat_o  out  DW   read data, valid with wb_ack_o
//   wb_ack_o  out  1    normal termination
//   wb_err_o  out  1    error termination (address outside window)
//   wb_rty_o  out  1    constant 0
// BEHAVIOUR
//   Reset: all outputs 0, FSM=IDLE, wait counter 0; memory contents NOT cleared.
//   FSM: IDLE -> (cyc&stb) -> WAIT if WAIT_STATES>0 else RESP.
//     WAIT counts WAIT_STATES cycles -> RESP. RESP asserts ack or err for that cycle.
//   Classic (cti!=010): single-cycle ack pulse.
//     First ack 1+WAIT_STATES cycles after cyc&stb sampled.
//     Then FSM -> IDLE; ack low >=1 cycle before the next transfer.
//   Burst (cti=010 at first beat): after first ack, FSM stays in BURST.
//     ack asserted every cycle while cyc&stb.
//     Internal beat address advances per BTE: linear +SW; wrapN keeps upper bits, increments low log2(N*SW) bits modulo N.
//     Read data is prefetched from the next beat address, so zero-wait beats are back-to-back.
//     wb_adr_i is ignored after the first beat.
//   Burst end: beat acked with cti=111 -> IDLE next cycle, ack low.
//   Burst stall: stb=0 with cyc=1 in BURST -> ack 0, address held, resume when stb returns.
//   cyc=0 at any time: next state IDLE, ack/err 0 next cycle. A pending write is discarded unless its ack already issued.
//   Write: on the acked cycle, mem[word] bytes with sel=1 take wb_dat_i; sel=0 bytes unchanged.
//   Read: wb_dat_o = mem[word] registered with ack. wb_dat_o holds its last value when ack=0.
//   Error: address outside [BASE_ADDR, BASE_ADDR+MEM_WORDS*SW) -> err instead of ack, same timing.
//     No memory write; wb_dat_o = 0.
//     A burst crossing the window top errs on the first out-of-window beat and ends (IDLE).
//   ack and err are never both 1. rty is always 0.
//   Read-after-write to the same word in consecutive beats returns the new data (write-first forwarding).
//   rst asserted mid-burst: next cycle outputs 0 and FSM=IDLE; the in-flight beat is lost.
// STRUCTURE
//   Package soc_wb_pkg: cti_t {CLASSIC=3'b000, CONST=3'b001, INCR=3'b010, EOB=3'b111};
//     bte_t {LINEAR, WRAP4, WRAP8, WRAP16}; fsm state enum {IDLE, WAIT, RESP, BURST}.
//   Sub-module soc_wb_burst_addr: combinational next-address from (adr, bte, SW).
//     Shared with future Wishbone initiators.
//   Memory: plain reg array with byte-enable write, inferable as BRAM.
// TESTING
//   1. WAIT_STATES=0, classic write 0xDEADBEEF @0x10 sel=1111, then read @0x10
//      -> ack 1 cycle after stb each time, read data 0xDEADBEEF.
//   2. Byte write sel=0010 data 0x0000AB00 over 0x11223344 -> read 0x1122AB44.
//   3. WAIT_STATES=3, classic read -> ack exactly 4 cycles after stb, ack pulse width 1.
//   4. INCR linear 4-beat read from 0x0, last beat cti=111
//      -> 4 consecutive acks, data mem[0..3], ack low the next cycle.
//   5. WRAP4 read starting at 0x8 -> beat addresses 0x8, 0xC, 0x0, 0x4.
//      Same with a stb=0 gap after beat 2 -> ack low in the gap, no address skip.
//   6. Access at BASE_ADDR+MEM_WORDS*4 -> err=1, ack=0, memory unchanged.
//      Assert rst mid-burst -> all outputs 0 the next cycle, then a fresh classic read works.

Source files
------------

// File: rtl/soc_wb_pkg.sv
// Shared Wishbone B3 cycle/burst types and the responder state encoding.
package soc_wb_pkg;

  typedef enum logic [2:0] {
    CLASSIC = 3'b000,
    CONST   = 3'b001,
    INCR    = 3'b010,
    EOB     = 3'b111
  } cti_t;

  typedef enum logic [1:0] {
    LINEAR = 2'b00,
    WRAP4  = 2'b01,
    WRAP8  = 2'b10,
    WRAP16 = 2'b11
  } bte_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    BURST
  } wb_state_t;

endpackage

// File: rtl/soc_wb_ext_responder_if.sv
// Wishbone B3 external-bus bundle; the master drives the *_i signals, the responder the *_o ones.
interface soc_wb_ext_responder_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 32
) ();

  logic [AW-1:0]   wb_adr_i;
  logic [DW-1:0]   wb_dat_i;
  logic [DW/8-1:0] wb_sel_i;
  logic            wb_we_i;
  logic            wb_cyc_i;
  logic            wb_stb_i;
  logic [2:0]      wb_cti_i;
  logic [1:0]      wb_bte_i;
  logic            wb_cab_i;
  logic [DW-1:0]   wb_dat_o;
  logic            wb_ack_o;
  logic            wb_err_o;
  logic            wb_rty_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
           wb_cab_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
           wb_cab_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );

endinterface

// File: rtl/soc_wb_burst_addr.sv
// Next beat address of a Wishbone incrementing burst: linear step or wrap within an N-beat block.
module soc_wb_burst_addr
  import soc_wb_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned SW = 4
) (
  input  logic [AW-1:0] adr,
  input  bte_t          bte,
  output logic [AW-1:0] nxt
);

  logic [AW-1:0] inc;
  logic [AW-1:0] mask;

  // Bits under mask come from the incremented address, the rest stay put.
  always_comb begin
    inc = adr + AW'(SW);
    unique case (bte)
      LINEAR: mask = '1;
      WRAP4:  mask = AW'(4 * SW - 1);
      WRAP8:  mask = AW'(8 * SW - 1);
      WRAP16: mask = AW'(16 * SW - 1);
      default: mask = '1;
    endcase
    nxt = (adr & ~mask) | (inc & mask);
  end

endmodule

// File: rtl/soc_wb_ext_responder.sv
// Wishbone B3 responder for the external bus: word memory answering classic and incrementing
// bursts, with wait states before the first ack and err outside the decoded window.
module soc_wb_ext_responder
  import soc_wb_pkg::*;
#(
  parameter int unsigned   DW          = 32,
  parameter int unsigned   AW          = 32,
  parameter int unsigned   MEM_WORDS   = 1024,
  parameter logic [AW-1:0] BASE_ADDR   = '0,
  parameter int unsigned   WAIT_STATES = 0
) (
  input logic                   clk,
  input logic                   rst,
  soc_wb_ext_responder_if.slave wb
);

  localparam int unsigned SW      = DW / 8;
  localparam int unsigned LOG_SW  = $clog2(SW);
  localparam int unsigned LOG_MEM = $clog2(MEM_WORDS);
  localparam int unsigned LOG_WIN = LOG_SW + LOG_MEM;

  wb_state_t          state_q;
  logic [3:0]         cnt_q;
  logic               ack_q, err_q, burst_q;
  logic [DW-1:0]      dat_q;
  logic [AW-1:0]      adr_q, nxt_adr, iss_adr;
  bte_t               bte_q;
  logic               req, iss_ok, wr_en;
  logic [LOG_MEM-1:0] wr_word, iss_word;
  logic [DW-1:0]      iss_dat;
  logic [DW-1:0]      mem [MEM_WORDS];
  logic               unused_ok;

  assign req = wb.wb_cyc_i & wb.wb_stb_i;

  soc_wb_burst_addr #(
    .AW (AW),
    .SW (SW)
  ) u_burst_addr (
    .adr (adr_q),
    .bte (bte_q),
    .nxt (nxt_adr)
  );

  // Address of the beat whose response is loaded at this edge.
  always_comb begin
    case (state_q)
      IDLE:    iss_adr = wb.wb_adr_i;
      BURST:   iss_adr = nxt_adr;
      default: iss_adr = adr_q;
    endcase
  end

  assign iss_ok   = (iss_adr >> LOG_WIN) == (BASE_ADDR >> LOG_WIN);
  assign iss_word = iss_adr[LOG_SW +: LOG_MEM];
  assign wr_word  = adr_q[LOG_SW +: LOG_MEM];

  // A beat commits on the edge where the master sees its ack; erred beats never write.
  assign wr_en = ~rst & req & ack_q & wb.wb_we_i & ((state_q == RESP) | (state_q == BURST));

  always_comb begin
    iss_dat = mem[iss_word];
    for (int b = 0; b < SW; b++) begin
      if (wr_en && (wr_word == iss_word) && wb.wb_sel_i[b]) begin
        iss_dat[8*b +: 8] = wb.wb_dat_i[8*b +: 8];
      end
    end
    if (!iss_ok) iss_dat = '0;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < SW; b++) begin
        if (wb.wb_sel_i[b]) mem[wr_word][8*b +: 8] <= wb.wb_dat_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      burst_q <= 1'b0;
      dat_q   <= '0;
      adr_q   <= '0;
      bte_q   <= LINEAR;
    end else begin
      unique case (state_q)
        IDLE: begin
          ack_q <= 1'b0;
          err_q <= 1'b0;
          if (req) begin
            adr_q   <= wb.wb_adr_i;
            bte_q   <= bte_t'(wb.wb_bte_i);
            burst_q <= (wb.wb_cti_i == INCR);
            if (WAIT_STATES == 0) begin
              ack_q   <= iss_ok;
              err_q   <= ~iss_ok;
              dat_q   <= iss_dat;
              state_q <= ((wb.wb_cti_i == INCR) && iss_ok) ? BURST : RESP;
            end else begin
              cnt_q   <= '0;
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!wb.wb_cyc_i) begin
            state_q <= IDLE;
          end else if (cnt_q == 4'(WAIT_STATES - 1)) begin
            ack_q   <= iss_ok;
            err_q   <= ~iss_ok;
            dat_q   <= iss_dat;
            state_q <= (burst_q && iss_ok) ? BURST : RESP;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        RESP: begin
          if (!wb.wb_cyc_i || wb.wb_stb_i) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        BURST: begin
          if (!wb.wb_cyc_i) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
          end else if (wb.wb_stb_i) begin
            if (err_q || (wb.wb_cti_i != INCR)) begin
              state_q <= IDLE;
              ack_q   <= 1'b0;
              err_q   <= 1'b0;
            end else begin
              adr_q <= nxt_adr;
              ack_q <= iss_ok;
              err_q <= ~iss_ok;
              dat_q <= iss_dat;
            end
          end
          // stb low: hold the prefetched beat until the master resumes
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wb.wb_ack_o = ack_q & req;
  assign wb.wb_err_o = err_q & req;
  assign wb.wb_rty_o = 1'b0;
  assign wb.wb_dat_o = dat_q;

  assign unused_ok = ^{wb.wb_cab_i, iss_adr};

endmodule

// File: tb/tb_soc_wb_ext_responder.sv
// Bench for soc_wb_ext_responder: zero- and three-wait-state instances against a memory model.
module tb_soc_wb_ext_responder;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned MW = 1024;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  soc_wb_ext_responder_if #(.DW(DW), .AW(AW)) wb0 ();
  soc_wb_ext_responder_if #(.DW(DW), .AW(AW)) wb3 ();

  soc_wb_ext_responder #(
    .DW (DW), .AW (AW), .MEM_WORDS (MW), .BASE_ADDR (32'h0), .WAIT_STATES (0)
  ) dut0 (
    .clk (clk), .rst (rst), .wb (wb0)
  );

  soc_wb_ext_responder #(
    .DW (DW), .AW (AW), .MEM_WORDS (MW), .BASE_ADDR (32'h0), .WAIT_STATES (3)
  ) dut3 (
    .clk (clk), .rst (rst), .wb (wb3)
  );

  // One bench master, steered to either instance by tgt.
  logic [31:0] m_adr, m_dat;
  logic [3:0]  m_sel;
  logic        m_we, m_cyc, m_stb;
  logic [2:0]  m_cti;
  logic [1:0]  m_bte;
  logic        tgt;
  logic        s_ack, s_err, s_rty;
  logic [31:0] s_dat;

  assign wb0.wb_adr_i = m_adr;  assign wb3.wb_adr_i = m_adr;
  assign wb0.wb_dat_i = m_dat;  assign wb3.wb_dat_i = m_dat;
  assign wb0.wb_sel_i = m_sel;  assign wb3.wb_sel_i = m_sel;
  assign wb0.wb_we_i  = m_we;   assign wb3.wb_we_i  = m_we;
  assign wb0.wb_cti_i = m_cti;  assign wb3.wb_cti_i = m_cti;
  assign wb0.wb_bte_i = m_bte;  assign wb3.wb_bte_i = m_bte;
  assign wb0.wb_cab_i = 1'b0;   assign wb3.wb_cab_i = 1'b0;
  assign wb0.wb_cyc_i = m_cyc & ~tgt;
  assign wb3.wb_cyc_i = m_cyc & tgt;
  assign wb0.wb_stb_i = m_stb & ~tgt;
  assign wb3.wb_stb_i = m_stb & tgt;
  assign s_ack = tgt ? wb3.wb_ack_o : wb0.wb_ack_o;
  assign s_err = tgt ? wb3.wb_err_o : wb0.wb_err_o;
  assign s_rty = tgt ? wb3.wb_rty_o : wb0.wb_rty_o;
  assign s_dat = tgt ? wb3.wb_dat_o : wb0.wb_dat_o;

  logic [31:0] model [2][MW];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Beat k of a burst starting at s, from the burst-type rules.
  function automatic logic [31:0] beat_adr(input logic [31:0] s, input logic [1:0] bte,
                                           input int unsigned k);
    int unsigned n, w;
    if (bte == 2'b00) return s + 32'(4 * k);
    n = 32'd4 << (bte - 2'd1);
    w = (s / 4) % n;
    return (s & ~32'(n * 4 - 1)) + 32'(((w + k) % n) * 4);
  endfunction

  task automatic classic(input logic t, input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel,
                         output logic [31:0] rd);
    int unsigned lat;
    logic seen, ack_v, err_v, in_win;
    in_win = (adr < 32'(MW * 4));
    tgt = t; m_we = we; m_adr = adr; m_dat = dat; m_sel = sel;
    m_cti = CTI_CLASSIC; m_bte = 2'b00; m_cyc = 1'b1; m_stb = 1'b1;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      seen = s_ack | s_err;
    end
    ack_v = s_ack; err_v = s_err; rd = s_dat;
    chk("classic_latency", lat, t ? 32'd4 : 32'd1);
    chk("classic_ack", 32'(ack_v), 32'(in_win));
    chk("classic_err", 32'(err_v), 32'(!in_win));
    if (!we) chk("classic_rdata", rd, in_win ? model[t][adr[11:2]] : 32'h0);
    @(posedge clk); #1;
    chk("classic_pulse", 32'(s_ack | s_err), 32'h0);
    m_cyc = 1'b0; m_stb = 1'b0;
    if (we && in_win) model[t][adr[11:2]] = merge(model[t][adr[11:2]], dat, sel);
  endtask

  task automatic burst(input logic t, input logic we, input logic [31:0] start,
                       input logic [1:0] bte, input int unsigned n, input int gap_at,
                       input int unsigned gap_len);
    logic [31:0] d [16];
    logic [3:0]  s [16];
    logic [31:0] a;
    int unsigned k, miss, guard, gap_left;
    logic got;
    for (int i = 0; i < 16; i++) begin
      d[i] = $urandom;
      s[i] = 4'($urandom);
    end
    tgt = t; m_we = we; m_bte = bte; m_adr = start; m_dat = d[0]; m_sel = s[0];
    m_cti = (n == 1) ? CTI_EOB : CTI_INCR; m_cyc = 1'b1; m_stb = 1'b1;
    k = 0; miss = 0; guard = 0; gap_left = 0; got = 1'b0;
    while (k < n && guard < 100) begin
      #1;
      if (!m_stb) begin
        chk("burst_gap_ack", 32'(s_ack | s_err), 32'h0);
      end else if (s_ack || s_err) begin
        a = beat_adr(start, bte, k);
        chk("burst_beat_wait", miss, (k == 0) ? (t ? 32'd4 : 32'd1) : 32'd0);
        chk("burst_beat_ack", 32'(s_ack), 32'h1);
        if (!we) chk("burst_beat_data", s_dat, model[t][a[11:2]]);
        k++; miss = 0; got = 1'b1;
      end else begin
        miss++;
      end
      @(posedge clk); #1;
      guard++;
      if (got) begin
        got = 1'b0;
        a = beat_adr(start, bte, k - 1);
        if (we) model[t][a[11:2]] = merge(model[t][a[11:2]], d[k-1], s[k-1]);
        if (k < n) begin
          m_adr = $urandom;
          m_dat = d[k]; m_sel = s[k];
          m_cti = (k == n - 1) ? CTI_EOB : CTI_INCR;
          if (int'(k) == gap_at) begin
            m_stb = 1'b0; gap_left = gap_len;
          end
        end
      end else if (gap_left > 0) begin
        gap_left--;
        if (gap_left == 0) m_stb = 1'b1;
      end
    end
    chk("burst_beats", k, n);
    #1;
    chk("burst_end_ack", 32'(s_ack | s_err), 32'h0);
    m_cyc = 1'b0; m_stb = 1'b0;
  endtask

  logic [31:0] rd;
  logic [31:0] adr;
  logic        t_r, we_r, oow;
  logic [1:0]  bte_r;
  int unsigned n_r, w_r;
  int          gap_r;

  initial begin
    m_adr = '0; m_dat = '0; m_sel = '0; m_we = 1'b0; m_cyc = 1'b0; m_stb = 1'b0;
    m_cti = CTI_CLASSIC; m_bte = 2'b00; tgt = 1'b0; rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      tgt = i[0];
      #1;
      chk("reset_ack", 32'(s_ack), 32'h0);
      chk("reset_err", 32'(s_err), 32'h0);
      chk("reset_dat", s_dat, 32'h0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    for (int t = 0; t < 2; t++) begin
      for (int w = 0; w < 64; w++) classic(t[0], 1'b1, 32'(w * 4), $urandom, 4'hF, rd);
    end

    classic(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd);
    classic(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, rd);
    chk("full_word_read", rd, 32'hDEADBEEF);
    classic(1'b0, 1'b1, 32'h14, 32'h11223344, 4'hF, rd);
    classic(1'b0, 1'b1, 32'h14, 32'h0000AB00, 4'b0010, rd);
    classic(1'b0, 1'b0, 32'h14, 32'h0, 4'h0, rd);
    chk("byte_lane_merge", rd, 32'h1122AB44);
    classic(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, rd);

    burst(1'b0, 1'b0, 32'h0, 2'b00, 4, -1, 0);
    burst(1'b0, 1'b0, 32'h8, 2'b01, 4, -1, 0);
    burst(1'b0, 1'b0, 32'h8, 2'b01, 4, 2, 1);
    burst(1'b1, 1'b0, 32'h30, 2'b10, 8, 3, 2);

    classic(1'b0, 1'b1, 32'(MW * 4), 32'hCAFEF00D, 4'hF, rd);
    classic(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, rd);
    classic(1'b0, 1'b0, 32'(MW * 4), 32'h0, 4'h0, rd);
    chk("rty_const", 32'(s_rty), 32'h0);

    // Reset lands two beats into a linear read burst.
    tgt = 1'b0; m_we = 1'b0; m_adr = 32'h0; m_bte = 2'b00; m_cti = CTI_INCR;
    m_cyc = 1'b1; m_stb = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midburst_rst_ack", 32'(s_ack), 32'h0);
    chk("midburst_rst_err", 32'(s_err), 32'h0);
    chk("midburst_rst_dat", s_dat, 32'h0);
    rst = 1'b0; m_cyc = 1'b0; m_stb = 1'b0;
    @(posedge clk); #1;
    classic(1'b0, 1'b0, 32'h14, 32'h0, 4'h0, rd);

    for (int i = 0; i < 40; i++) begin
      t_r = 1'($urandom); we_r = 1'($urandom);
      oow = ($urandom_range(0, 4) == 0);
      adr = 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
      if (oow) adr = adr + 32'h1000 * 32'($urandom_range(1, 1000));
      classic(t_r, we_r, adr, $urandom, 4'($urandom), rd);
    end

    for (int i = 0; i < 16; i++) begin
      t_r = 1'($urandom); we_r = 1'($urandom); bte_r = 2'($urandom);
      n_r = $urandom_range(1, 8);
      w_r = (bte_r == 2'b00) ? $urandom_range(0, 63 - n_r) : $urandom_range(0, 63);
      gap_r = (n_r > 1 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, n_r - 1)) : -1;
      burst(t_r, we_r, 32'(w_r * 4), bte_r, n_r, gap_r, $urandom_range(1, 2));
    end

    for (int w = 0; w < 64; w++) classic(1'b0, 1'b0, 32'(w * 4), 32'h0, 4'h0, rd);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
